// File: rtl/lane_align_pkg.sv
// lane_align_pkg
//   Shared definitions for the DDR lane alignment sequencer:
//   - align_state_e : sequencer FSM state enum
//   - *_CNT_W       : counter widths sized for the legal parameter ranges
//                     (SETTLE_CYCLES 2..255, MATCH_CYCLES 1..255, MAX_SLIPS 1..15)
//   - lane_idx_w    : width of a lane index, never narrower than one bit
package lane_align_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    NEXT,
    DONE
  } align_state_e;

  localparam int unsigned SETTLE_CNT_W = 8;
  localparam int unsigned MATCH_CNT_W  = 8;
  localparam int unsigned SLIP_CNT_W   = 4;

  function automatic int unsigned lane_idx_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/lane_align_ctrl.sv
// lane_align_ctrl
//   Walks every DDR lane in turn: waits for the data to settle, compares the
//   corrected rise/fall bits against the expected training pattern, requests a
//   bitslip on mismatch and retries, and marks each lane locked or failed.
//
//   Ports
//     dco_clk        sole clock, rising edge
//     rst            synchronous active-high reset, overrides everything
//     start          one-cycle pulse, begins a pass (ignored while busy)
//     lane_rise/fall corrected data bits from the bitslip stage
//     exp_rise/fall  expected training bits, static during a pass
//     bitslip_pulse  one-hot, one-cycle slip request for cur_lane
//     busy           high from the cycle after start until done
//     done           one-cycle end-of-pass pulse
//     lane_locked    per-lane lock flags
//     lane_fail      per-lane failure flags
//     cur_lane       lane currently being aligned
//     realign_req    loss-of-lock indication
//
//   Build option
//     LANE_ALIGN_MONITOR_EN : when defined, a locked lane that mismatches while
//     idle loses its lock bit and sets realign_req until the next start/rst.
//     When undefined realign_req is constant 0 and no monitor logic exists.
module lane_align_ctrl
  import lane_align_pkg::*;
#(
  parameter int unsigned LANES         = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MATCH_CYCLES  = 16,
  parameter int unsigned MAX_SLIPS     = 3
) (
  input  logic                         dco_clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LANES-1:0]             lane_rise,
  input  logic [LANES-1:0]             lane_fall,
  input  logic [LANES-1:0]             exp_rise,
  input  logic [LANES-1:0]             exp_fall,
  output logic [LANES-1:0]             bitslip_pulse,
  output logic                         busy,
  output logic                         done,
  output logic [LANES-1:0]             lane_locked,
  output logic [LANES-1:0]             lane_fail,
  output logic [lane_idx_w(LANES)-1:0] cur_lane,
  output logic                         realign_req
);

  localparam int unsigned LANE_W = lane_idx_w(LANES);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_CNT_W-1:0]  MATCH_LAST  = MATCH_CNT_W'(MATCH_CYCLES - 1);
  localparam logic [SLIP_CNT_W-1:0]   SLIP_LIMIT  = SLIP_CNT_W'(MAX_SLIPS);
  localparam logic [LANE_W-1:0]       LAST_LANE   = LANE_W'(LANES - 1);

  align_state_e            state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [MATCH_CNT_W-1:0]  match_cnt;
  logic [SLIP_CNT_W-1:0]   slip_cnt;

  logic [LANES-1:0] lane_sel;
  logic [LANES-1:0] lane_ok;
  logic             cur_match;

  // One-hot decode of cur_lane; doubles as the slip request vector and as
  // the mask that picks the active lane out of the per-lane match vector.
  always_comb begin
    lane_sel = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sel[i] = (cur_lane == LANE_W'(i));
    end
  end

  assign lane_ok   = ~((lane_rise ^ exp_rise) | (lane_fall ^ exp_fall));
  assign cur_match = |(lane_sel & lane_ok);

`ifdef LANE_ALIGN_MONITOR_EN
  logic [LANES-1:0] lock_loss;
  assign lock_loss = lane_locked & ~lane_ok;
`else
  assign realign_req = 1'b0;
`endif

  always_ff @(posedge dco_clk) begin
    if (rst) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      match_cnt     <= '0;
      slip_cnt      <= '0;
      cur_lane      <= '0;
      bitslip_pulse <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lane_locked   <= '0;
      lane_fail     <= '0;
`ifdef LANE_ALIGN_MONITOR_EN
      realign_req   <= 1'b0;
`endif
    end else begin
      bitslip_pulse <= '0;
      done          <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            lane_locked <= '0;
            lane_fail   <= '0;
            cur_lane    <= '0;
            settle_cnt  <= '0;
            match_cnt   <= '0;
            slip_cnt    <= '0;
            busy        <= 1'b1;
`ifdef LANE_ALIGN_MONITOR_EN
            realign_req <= 1'b0;
`endif
            state       <= SETTLE;
          end
`ifdef LANE_ALIGN_MONITOR_EN
          else if (|lock_loss) begin
            lane_locked <= lane_locked & ~lock_loss;
            realign_req <= 1'b1;
          end
`endif
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            match_cnt  <= '0;
            state      <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (cur_match) begin
            match_cnt <= match_cnt + 1'b1;
            if (match_cnt == MATCH_LAST) begin
              lane_locked <= lane_locked | lane_sel;
              state       <= NEXT;
            end
          end else if (slip_cnt == SLIP_LIMIT) begin
            lane_fail <= lane_fail | lane_sel;
            state     <= NEXT;
          end else begin
            // The pulse register is loaded here so it is high exactly during
            // the SLIP cycle and low in every other state.
            bitslip_pulse <= lane_sel;
            state         <= SLIP;
          end
        end

        SLIP: begin
          slip_cnt   <= slip_cnt + 1'b1;
          settle_cnt <= '0;
          state      <= SETTLE;
        end

        NEXT: begin
          slip_cnt   <= '0;
          match_cnt  <= '0;
          settle_cnt <= '0;
          if (cur_lane == LAST_LANE) begin
            state <= DONE;
          end else begin
            cur_lane <= cur_lane + 1'b1;
            state    <= SETTLE;
          end
        end

        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_align_ctrl.sv
module tb_lane_align_ctrl;

  localparam int unsigned LANES = 8;
  localparam int unsigned SC    = 4;
  localparam int unsigned MC    = 16;
  localparam int unsigned MS    = 3;
  localparam int unsigned CW    = $clog2(LANES);

  logic             dco_clk   = 1'b0;
  logic             rst       = 1'b1;
  logic             start     = 1'b0;
  logic [LANES-1:0] lane_rise = '0;
  logic [LANES-1:0] lane_fall = '0;
  logic [LANES-1:0] exp_rise  = '0;
  logic [LANES-1:0] exp_fall  = '0;
  logic [LANES-1:0] bitslip_pulse;
  logic [LANES-1:0] lane_locked;
  logic [LANES-1:0] lane_fail;
  logic             busy;
  logic             done;
  logic             realign_req;
  logic [CW-1:0]    cur_lane;

  lane_align_ctrl #(
    .LANES(LANES),
    .SETTLE_CYCLES(SC),
    .MATCH_CYCLES(MC),
    .MAX_SLIPS(MS)
  ) dut (
    .dco_clk(dco_clk),
    .rst(rst),
    .start(start),
    .lane_rise(lane_rise),
    .lane_fall(lane_fall),
    .exp_rise(exp_rise),
    .exp_fall(exp_fall),
    .bitslip_pulse(bitslip_pulse),
    .busy(busy),
    .done(done),
    .lane_locked(lane_locked),
    .lane_fail(lane_fail),
    .cur_lane(cur_lane),
    .realign_req(realign_req)
  );

  always #5 dco_clk = ~dco_clk;

  // One entry per clock cycle: the inputs driven in that cycle and the
  // outputs the design must show in that same cycle.
  typedef struct {
    logic             start;
    logic             rst;
    logic             chk;
    logic [LANES-1:0] xr;
    logic [LANES-1:0] xf;
    logic [LANES-1:0] rise;
    logic [LANES-1:0] fall;
    logic [LANES-1:0] pulse;
    logic [LANES-1:0] locked;
    logic [LANES-1:0] fail;
    int unsigned      cur;
    logic             busy;
    logic             done;
    logic             realign;
  } ent_t;

  ent_t sched[$];
  ent_t cur_e;
  logic have_e = 1'b0;

  int errors = 0;
  int checks = 0;

  // Model view of the outputs while building a timeline.
  logic [LANES-1:0] m_locked  = '0;
  logic [LANES-1:0] m_fail    = '0;
  int unsigned      m_cur     = 0;
  logic             m_realign = 1'b0;
  logic [LANES-1:0] x_rise    = '0;
  logic [LANES-1:0] x_fall    = '0;
  bit               xs_en     = 1'b0;
  // Slips a lane needs before its data lines up; MS+1 means it never does.
  int unsigned      need_cfg [LANES];

  int unsigned cyc = 0;
  int unsigned st_cyc = 0;
  int unsigned lat = 0;
  int unsigned pcnt [LANES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic b, input logic [LANES-1:0] p);
    ent_t e;
    e.start   = 1'b0;
    e.rst     = 1'b0;
    e.chk     = 1'b1;
    e.xr      = x_rise;
    e.xf      = x_fall;
    e.rise    = LANES'($urandom);
    e.fall    = LANES'($urandom);
    e.pulse   = p;
    e.locked  = m_locked;
    e.fail    = m_fail;
    e.cur     = m_cur;
    e.busy    = b;
    e.done    = 1'b0;
    e.realign = m_realign;
    return e;
  endfunction

  function automatic ent_t idle_ent();
    ent_t e;
    e = mk(1'b0, '0);
    e.rise = x_rise;
    e.fall = x_fall;
    return e;
  endfunction

  function automatic ent_t on_lane(input ent_t e_in, input int unsigned l, input bit ok);
    ent_t e;
    int unsigned k;
    e = e_in;
    e.rise[l] = x_rise[l];
    e.fall[l] = x_fall[l];
    if (!ok) begin
      k = $urandom_range(1, 3);
      if (k != 2) e.rise[l] = ~x_rise[l];
      if (k != 1) e.fall[l] = ~x_fall[l];
    end
    return e;
  endfunction

  task automatic push(input ent_t e_in);
    ent_t e;
    e = e_in;
    if (xs_en && e.busy && ($urandom_range(0, 7) == 0)) e.start = 1'b1;
    sched.push_back(e);
  endtask

  // Timeline of one full pass: per lane, settle, then either a clean run of
  // MC matches (lock) or some matches and a mismatch followed by a slip, until
  // the lane lines up or runs out of slips.
  task automatic build_pass(input bit noisy);
    ent_t e;
    logic [LANES-1:0] oh;
    int unsigned slips;
    int unsigned k;
    bit fin;
    e = idle_ent();
    e.start = 1'b1;
    sched.push_back(e);
    m_locked  = '0;
    m_fail    = '0;
    m_cur     = 0;
    m_realign = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      m_cur = l;
      slips = 0;
      fin   = 1'b0;
      oh    = '0;
      oh[l] = 1'b1;
      while (!fin) begin
        for (int unsigned i = 0; i < SC; i++) push(mk(1'b1, '0));
        if (slips == need_cfg[l]) begin
          for (int unsigned i = 0; i < MC; i++) push(on_lane(mk(1'b1, '0), l, 1'b1));
          m_locked[l] = 1'b1;
          push(mk(1'b1, '0));
          fin = 1'b1;
        end else begin
          k = noisy ? $urandom_range(0, MC - 1) : 0;
          for (int unsigned i = 0; i < k; i++) push(on_lane(mk(1'b1, '0), l, 1'b1));
          push(on_lane(mk(1'b1, '0), l, 1'b0));
          if (slips < MS) begin
            push(mk(1'b1, oh));
            slips++;
          end else begin
            m_fail[l] = 1'b1;
            push(mk(1'b1, '0));
            fin = 1'b1;
          end
        end
      end
    end
    push(mk(1'b1, '0));
    e = idle_ent();
    e.done = 1'b1;
    sched.push_back(e);
    for (int unsigned i = 0; i < 3; i++) sched.push_back(idle_ent());
  endtask

  function automatic int done_offset();
    for (int i = 0; i < sched.size(); i++) begin
      if (sched[i].done) return i;
    end
    return -1;
  endfunction

  task automatic set_need(input int unsigned v);
    for (int unsigned l = 0; l < LANES; l++) need_cfg[l] = v;
  endtask

  task automatic run_sched();
    while (sched.size() > 0) begin
      @(posedge dco_clk);
      #1;
      cur_e     = sched.pop_front();
      rst       = cur_e.rst;
      start     = cur_e.start;
      exp_rise  = cur_e.xr;
      exp_fall  = cur_e.xf;
      lane_rise = cur_e.rise;
      lane_fall = cur_e.fall;
      have_e    = 1'b1;
    end
    @(negedge dco_clk);
    #1;
  endtask

  function automatic int unsigned pulse_total();
    int unsigned t;
    t = 0;
    for (int unsigned l = 0; l < LANES; l++) t += pcnt[l];
    return t;
  endfunction

  // Single compare process: every scheduled cycle, all outputs against the
  // timeline; also gathers latency and pulse counts for the literal checks.
  always @(negedge dco_clk) begin
    cyc++;
    if (have_e) begin
      if (cur_e.start && !cur_e.busy && !cur_e.rst) begin
        st_cyc = cyc;
        lat    = 0;
        for (int unsigned l = 0; l < LANES; l++) pcnt[l] = 0;
      end
      for (int unsigned l = 0; l < LANES; l++) begin
        if (bitslip_pulse[l]) pcnt[l]++;
      end
      if (done) lat = cyc - st_cyc;
      if (cur_e.chk) begin
        chk("bitslip_pulse", 32'(bitslip_pulse), 32'(cur_e.pulse));
        chk("busy",          32'(busy),          32'(cur_e.busy));
        chk("done",          32'(done),          32'(cur_e.done));
        chk("lane_locked",   32'(lane_locked),   32'(cur_e.locked));
        chk("lane_fail",     32'(lane_fail),     32'(cur_e.fail));
        chk("cur_lane",      32'(cur_lane),      cur_e.cur);
        chk("realign_req",   32'(realign_req),   32'(cur_e.realign));
      end
    end
  end

  initial begin
    ent_t e;
    int   off;

    // Power-on reset; outputs are undefined before the first edge.
    for (int i = 0; i < 3; i++) begin
      e = idle_ent();
      e.rst = 1'b1;
      e.chk = (i > 0);
      sched.push_back(e);
    end
    for (int i = 0; i < 2; i++) sched.push_back(idle_ent());
    run_sched();

    // All lanes aligned: no slips, every lane locks.
    x_rise = '1;
    x_fall = '0;
    set_need(0);
    build_pass(1'b0);
    off = done_offset();
    chk("model_done_offset", 32'(off), 32'(8 * (4 + 16 + 1) + 2));
    run_sched();
    chk("aligned_latency", lat, 170);
    chk("aligned_locked", 32'(lane_locked), 32'h0000_00ff);
    chk("aligned_fail", 32'(lane_fail), 32'h0);
    chk("aligned_pulses", pulse_total(), 0);

    // Lane 3 needs exactly one slip.
    set_need(0);
    need_cfg[3] = 1;
    build_pass(1'b0);
    run_sched();
    chk("lane3_pulses", pcnt[3], 1);
    chk("lane3_total_pulses", pulse_total(), 1);
    chk("lane3_locked", 32'(lane_locked), 32'h0000_00ff);
    chk("lane3_fail", 32'(lane_fail), 32'h0);

    // Corrupt lane 1 for one idle cycle.
    e = idle_ent();
    e.rise[1] = ~x_rise[1];
    sched.push_back(e);
`ifdef LANE_ALIGN_MONITOR_EN
    m_locked[1] = 1'b0;
    m_realign   = 1'b1;
`endif
    for (int i = 0; i < 3; i++) sched.push_back(idle_ent());
    run_sched();
`ifdef LANE_ALIGN_MONITOR_EN
    chk("monitor_locked", 32'(lane_locked), 32'h0000_00fd);
    chk("monitor_realign", 32'(realign_req), 32'h1);
`else
    chk("monitor_locked", 32'(lane_locked), 32'h0000_00ff);
    chk("monitor_realign", 32'(realign_req), 32'h0);
`endif

    // Lane 5 never lines up: three slips, then failure.
    set_need(0);
    need_cfg[5] = MS + 1;
    build_pass(1'b0);
    run_sched();
    chk("lane5_pulses", pcnt[5], 3);
    chk("lane5_total_pulses", pulse_total(), 3);
    chk("lane5_fail", 32'(lane_fail), 32'h0000_0020);
    chk("lane5_locked", 32'(lane_locked), 32'h0000_00df);
    chk("lane5_latency", lat, 173);

    // Reset during the 4th CHECK cycle of lane 2, then a complete pass.
    set_need(0);
    build_pass(1'b0);
    while (sched.size() > 51) void'(sched.pop_back());
    sched[50].rst = 1'b1;
    m_locked  = '0;
    m_fail    = '0;
    m_cur     = 0;
    m_realign = 1'b0;
    for (int i = 0; i < 4; i++) sched.push_back(idle_ent());
    run_sched();
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_locked", 32'(lane_locked), 32'h0);
    build_pass(1'b0);
    run_sched();
    chk("after_reset_latency", lat, 170);
    chk("after_reset_locked", 32'(lane_locked), 32'h0000_00ff);

    // Extra start pulses while busy must change nothing.
    xs_en = 1'b1;
    build_pass(1'b0);
    run_sched();
    chk("restart_latency", lat, 170);
    chk("restart_locked", 32'(lane_locked), 32'h0000_00ff);

    // Randomized passes: random patterns, slip needs, noisy match runs.
    for (int p = 0; p < 6; p++) begin
      x_rise = LANES'($urandom);
      x_fall = LANES'($urandom);
      for (int unsigned l = 0; l < LANES; l++) need_cfg[l] = $urandom_range(0, MS + 1);
      build_pass(1'b1);
      run_sched();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_align_ctrl.md
LANE_ALIGN_CTRL -- requirements
Module: lane_align_ctrl

Interface
REQ-001 Parameter LANES, default 8: number of DDR lanes sequenced.
REQ-002 Parameter SETTLE_CYCLES, default 4, legal range 2..255: wait after a slip or lane select before comparing.
REQ-003 Parameter MATCH_CYCLES, default 16, legal range 1..255: consecutive matching cycles required for lock.
REQ-004 Parameter MAX_SLIPS, default 3, legal range 1..15: slips allowed per lane before failure.
REQ-005 One clock and one reset: dco_clk, with rst synchronous and active-high.
REQ-006 dco_clk  in  1  sole clock; all state updates on posedge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle pulse that begins a full alignment pass.
REQ-009 lane_rise  in  LANES  corrected rise bits from the bitslip stage.
REQ-010 lane_fall  in  LANES  corrected fall bits from the bitslip stage.
REQ-011 exp_rise  in  LANES  expected training rise bit per lane; static during a pass.
REQ-012 exp_fall  in  LANES  expected training fall bit per lane; static during a pass.
REQ-013 bitslip_pulse  out  LANES  one-hot, one-cycle slip request to the bitslip stage.
REQ-014 busy  out  1  high from the cycle after start until done.
REQ-015 done  out  1  one-cycle pulse at the end of a pass.
REQ-016 lane_locked  out  LANES  per-lane lock flags.
REQ-017 lane_fail  out  LANES  per-lane failure flags.
REQ-018 cur_lane  out  clog2(LANES)  index of the lane being aligned.
REQ-019 realign_req  out  1  loss-of-lock indication (see Configuration).

Function
REQ-020 FSM states: IDLE, SETTLE, CHECK, SLIP, NEXT, DONE.
REQ-021 IDLE + start: clear lane_locked, lane_fail, cur_lane, settle counter, match counter and slip counter; go to SETTLE.
REQ-022 start while busy is ignored.
REQ-023 SETTLE: count SETTLE_CYCLES cycles, ignoring lane data; then go to CHECK with the match counter at 0.
REQ-024 CHECK, match cycle: lane_rise[cur_lane]==exp_rise[cur_lane] and lane_fall[cur_lane]==exp_fall[cur_lane]; the match counter increments.
REQ-025 CHECK, match counter reaches MATCH_CYCLES: set lane_locked[cur_lane]; go to NEXT.
REQ-026 CHECK, any mismatch with slip counter < MAX_SLIPS: go to SLIP.
REQ-027 CHECK, any mismatch with slip counter == MAX_SLIPS: set lane_fail[cur_lane]; go to NEXT.
REQ-028 SLIP lasts exactly one cycle: bitslip_pulse[cur_lane]=1, all other bits 0, slip counter +1, then go to SETTLE.
REQ-029 bitslip_pulse is zero in every state except SLIP.
REQ-030 NEXT: clear slip and match counters; if cur_lane==LANES-1 go to DONE, else increment cur_lane and go to SETTLE; cur_lane never wraps inside a pass.
REQ-031 DONE lasts one cycle: done=1, busy=0 next cycle, return to IDLE.
REQ-032 lane_locked and lane_fail are mutually exclusive per lane and hold their values until the next start or reset.
REQ-033 Outputs are registered, with no combinational path from inputs to outputs.
REQ-034 Minimum pass length per lane: SETTLE_CYCLES + MATCH_CYCLES + 1 cycles.

Reset
REQ-035 rst has priority over start and all FSM activity at any cycle, including mid-pass.
REQ-036 During rst, all outputs are 0, all counters are 0, and the state is IDLE.

Configuration
REQ-037 Macro LANE_ALIGN_MONITOR_EN defined: in IDLE, any mismatch on a lane with lane_locked=1 clears that lock bit and sets realign_req; realign_req stays set until start or rst.
REQ-038 Macro LANE_ALIGN_MONITOR_EN undefined: realign_req is tied 0, lock bits change only per REQ-021/025, and no monitor logic is synthesized.

Structure
REQ-039 A shared package lane_align_pkg holds the FSM state enum and the counter-width localparams.
REQ-040 No sub-modules; lane_bitslip is instantiated beside this block, not inside it.

Verification
REQ-041 Lane data already aligned, LANES=8, exp_rise=all 1, exp_fall=all 0: after start, all lane_locked=1, no bitslip_pulse, done 8*(4+16+1)+2 cycles later.
REQ-042 Lane 3 phase-inverted, bitslip model toggles it: exactly one pulse on bit 3, then lane_locked[3]=1 and lane_fail=0.
REQ-043 Lane 5 tied to constant 0: three pulses on bit 5, then lane_fail[5]=1, all other lanes locked, done asserted.
REQ-044 rst asserted during CHECK of lane 2: the next cycle shows all outputs 0 and state IDLE; a later start runs a complete pass.
REQ-045 start pulsed again while busy: no effect on cur_lane, the flags, or done timing.
REQ-046 With LANE_ALIGN_MONITOR_EN: after the pass, corrupt lane 1 for one cycle; then lane_locked[1]=0 and realign_req=1; without the macro, realign_req stays 0.
